// File: rtl/if_id_skid.sv
// IF->ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Decode back-pressure stalls fetch without losing bundles; flush squashes everything held.
module if_id_skid #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      if_valid,
   output logic                      if_ready,
   input  logic [ADDR_W-1:0]         if_pc,
   input  logic [LANES*INST_W-1:0]   if_inst,
   input  logic [LANES-1:0]          if_lane_mask,
   output logic                      id_valid,
   input  logic                      id_ready,
   output logic [ADDR_W-1:0]         id_pc,
   output logic [LANES*INST_W-1:0]   id_inst,
   output logic [LANES-1:0]          id_lane_mask,
   output logic [CNT_W-1:0]          stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t                    state;
   logic [ADDR_W-1:0]         skid_pc;
   logic [LANES*INST_W-1:0]   skid_inst;
   logic [LANES-1:0]          skid_mask;
   logic                      acc;
   logic                      take;

   assign acc  = if_valid && if_ready;
   assign take = id_valid && id_ready;

   // id_valid and if_ready are kept as their own flops, updated alongside state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= EMPTY;
         id_valid     <= 1'b0;
         if_ready     <= 1'b1;
         id_pc        <= '0;
         id_inst      <= '0;
         id_lane_mask <= '0;
         skid_pc      <= '0;
         skid_inst    <= '0;
         skid_mask    <= '0;
         stall_cnt    <= '0;
      end else begin
         if (id_valid && !id_ready && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (flush) begin
            state        <= EMPTY;
            id_valid     <= 1'b0;
            if_ready     <= 1'b1;
            id_pc        <= '0;
            id_inst      <= '0;
            id_lane_mask <= '0;
            skid_pc      <= '0;
            skid_inst    <= '0;
            skid_mask    <= '0;
         end else begin
            case (state)
               EMPTY: begin
                  if (acc) begin
                     state        <= ONE;
                     id_valid     <= 1'b1;
                     id_pc        <= if_pc;
                     id_inst      <= if_inst;
                     id_lane_mask <= if_lane_mask;
                  end
               end
               ONE: begin
                  if (acc && take) begin
                     id_pc        <= if_pc;
                     id_inst      <= if_inst;
                     id_lane_mask <= if_lane_mask;
                  end else if (acc) begin
                     state     <= FULL;
                     if_ready  <= 1'b0;
                     skid_pc   <= if_pc;
                     skid_inst <= if_inst;
                     skid_mask <= if_lane_mask;
                  end else if (take) begin
                     // Zero the payload so an empty stage always presents a bubble.
                     state        <= EMPTY;
                     id_valid     <= 1'b0;
                     id_pc        <= '0;
                     id_inst      <= '0;
                     id_lane_mask <= '0;
                  end
               end
               FULL: begin
                  if (take) begin
                     state        <= ONE;
                     if_ready     <= 1'b1;
                     id_pc        <= skid_pc;
                     id_inst      <= skid_inst;
                     id_lane_mask <= skid_mask;
                     skid_pc      <= '0;
                     skid_inst    <= '0;
                     skid_mask    <= '0;
                  end
               end
               default: begin
                  state        <= EMPTY;
                  id_valid     <= 1'b0;
                  if_ready     <= 1'b1;
                  id_pc        <= '0;
                  id_inst      <= '0;
                  id_lane_mask <= '0;
               end
            endcase
         end
      end
   end

endmodule
